bits_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one small bit-arithmetic datapath among N requesters. Each requester offers a pair of bit operands over a valid/ready handshake. The block grants one requester, registers its operands, and runs the datapath for one cycle. It then holds the tagged 4-bit result until the consumer accepts it. It sits between independent operand producers and a single result consumer, and it sequences the only datapath instance.

---
 rtl/bits_arbiter_pkg.sv | 20 ++
 rtl/bits_arbiter_if.sv | 36 +++
 rtl/bits_sum_calc.sv | 16 +
 rtl/bits_arbiter.sv | 117 +++++++++++
 tb/tb_bits_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bits_arbiter_pkg.sv
// Shared definitions for the bits_arbiter slice.
//   bits_state_e     : sequencer states (IDLE -> CALC -> DONE -> IDLE)
//   BITS_ADD_OFFSET  : constant added to every operand pair by the datapath
//   bits_rr_next()   : round-robin successor of a granted index
package bits_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } bits_state_e;

    localparam int BITS_ADD_OFFSET = 3;

    // Index that gets first look on the next search after granting idx.
    function automatic int bits_rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/bits_arbiter_if.sv
// Bus between the requesters/consumer and the arbiter.
//   REQ_VALID/REQ_A/REQ_B/REQ_READY : N operand channels, slice i = requester i
//   RES_VALID/RES_READY/RES_DATA/RES_ID : single tagged result channel
//   BUSY/OP_COUNT : status from the arbiter
// Handshake semantics (both channels): a transfer happens on a rising clock
// edge where valid and ready are both high. A producer may withdraw valid
// before the transfer; the result producer (the arbiter) holds RES_DATA and
// RES_ID steady while RES_VALID is high and RES_READY is low.
// modport master: requester/consumer side; modport slave: arbiter side.
interface bits_arbiter_if #(
    parameter int N  = 4,
    parameter int W  = 1,
    parameter int RW = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) ();
    logic [N-1:0]   REQ_VALID;
    logic [N*W-1:0] REQ_A;
    logic [N*W-1:0] REQ_B;
    logic [N-1:0]   REQ_READY;
    logic           RES_VALID;
    logic           RES_READY;
    logic [RW-1:0]  RES_DATA;
    logic [IW-1:0]  RES_ID;
    logic           BUSY;
    logic [15:0]    OP_COUNT;

    modport master (
        output REQ_VALID, REQ_A, REQ_B, RES_READY,
        input  REQ_READY, RES_VALID, RES_DATA, RES_ID, BUSY, OP_COUNT
    );

    modport slave (
        input  REQ_VALID, REQ_A, REQ_B, RES_READY,
        output REQ_READY, RES_VALID, RES_DATA, RES_ID, BUSY, OP_COUNT
    );
endinterface

// File: rtl/bits_sum_calc.sv
// Combinational datapath: SUM = (A + B + BITS_ADD_OFFSET) mod 2^RW, unsigned.
//   A, B : W-bit operands
//   SUM  : RW-bit truncated result
module bits_sum_calc
    import bits_arbiter_pkg::*;
#(
    parameter int W  = 1,
    parameter int RW = 4
) (
    input  logic [W-1:0]  A,
    input  logic [W-1:0]  B,
    output logic [RW-1:0] SUM
);
    // Working in RW bits gives the modulo-2^RW wrap for free.
    assign SUM = RW'(A) + RW'(B) + RW'(BITS_ADD_OFFSET);
endmodule

// File: rtl/bits_arbiter.sv
// Round-robin arbiter sharing one bits_sum_calc among N requesters.
//   CLK, RST_N : clock, asynchronous active-low reset
//   bus        : bits_arbiter_if.slave (operand channels, result channel,
//                BUSY, OP_COUNT)
//   DBG_STATE  : current sequencer state
// One operation in flight: IDLE grants and registers operands, CALC latches
// the datapath result, DONE holds it until the consumer takes it.
module bits_arbiter
    import bits_arbiter_pkg::*;
#(
    parameter int N  = 4,
    parameter int W  = 1,
    parameter int RW = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          CLK,
    input  logic          RST_N,
    bits_arbiter_if.slave bus,
    output bits_state_e   DBG_STATE
);
    bits_state_e   state_q, state_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] id_q, id_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic [RW-1:0] res_q, res_d;
    logic [15:0]   op_count_q, op_count_d;

    logic [RW-1:0] sum;
    logic          gnt_found;
    logic [IW-1:0] gnt_idx;
    logic [N-1:0]  req_ready;

    bits_sum_calc #(
        .W  (W),
        .RW (RW)
    ) u_sum (
        .A   (a_q),
        .B   (b_q),
        .SUM (sum)
    );

    // First valid requester at or after ptr_q, wrapping around.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int k = 0; k < N; k++) begin
            if (!gnt_found && bus.REQ_VALID[(int'(ptr_q) + k) % N]) begin
                gnt_found = 1'b1;
                gnt_idx   = IW'((int'(ptr_q) + k) % N);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        id_d       = id_q;
        a_d        = a_q;
        b_d        = b_q;
        res_d      = res_q;
        op_count_d = op_count_q;
        req_ready  = '0;
        case (state_q)
            ST_IDLE: begin
                if (gnt_found) begin
                    req_ready[gnt_idx] = 1'b1;
                    a_d     = bus.REQ_A[int'(gnt_idx) * W +: W];
                    b_d     = bus.REQ_B[int'(gnt_idx) * W +: W];
                    id_d    = gnt_idx;
                    ptr_d   = IW'(bits_rr_next(int'(gnt_idx), N));
                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                res_d   = sum;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (bus.RES_READY) begin
                    op_count_d = op_count_q + 16'd1;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            id_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            res_q      <= '0;
            op_count_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            id_q       <= id_d;
            a_q        <= a_d;
            b_q        <= b_d;
            res_q      <= res_d;
            op_count_q <= op_count_d;
        end
    end

    assign bus.REQ_READY = req_ready;
    assign bus.RES_VALID = (state_q == ST_DONE);
    assign bus.RES_DATA  = res_q;
    assign bus.RES_ID    = id_q;
    assign bus.BUSY      = (state_q != ST_IDLE);
    assign bus.OP_COUNT  = op_count_q;
    assign DBG_STATE     = state_q;

endmodule

// File: tb/tb_bits_arbiter.sv
module tb_bits_arbiter;
  import bits_arbiter_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  int cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bits_arbiter_if #(.N(4), .W(1), .RW(4)) bus ();
  bits_arbiter_if #(.N(2), .W(2), .RW(4)) bus2 ();
  bits_arbiter_if #(.N(2), .W(2), .RW(3)) bus3 ();
  bits_state_e dbg, dbg2, dbg3;

  bits_arbiter #(.N(4), .W(1), .RW(4)) dut (.CLK(clk), .RST_N(rst_n), .bus(bus.slave), .DBG_STATE(dbg));
  bits_arbiter #(.N(2), .W(2), .RW(4)) dut2 (.CLK(clk), .RST_N(rst_n), .bus(bus2.slave), .DBG_STATE(dbg2));
  bits_arbiter #(.N(2), .W(2), .RW(3)) dut3 (.CLK(clk), .RST_N(rst_n), .bus(bus3.slave), .DBG_STATE(dbg3));

  // scoreboard: {id[1:0], data[3:0]}
  logic [5:0] exp_q[$];
  int n_checks = 0;
  int n_pass = 0;
  int m_ptr = 0;
  int m_ops = 0;

  function automatic int model_pick(input logic [3:0] v, input int p);
    for (int k = 0; k < 4; k++) if (v[(p + k) % 4]) return (p + k) % 4;
    return 0;
  endfunction

  function automatic logic [3:0] model_res(input logic a, input logic b);
    return {3'b0, a} + {3'b0, b} + 4'd3;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    n_checks++; if (bus.REQ_READY !== 4'b0) $display("FAIL reset_req_ready got=%b exp=0000", bus.REQ_READY); else n_pass++;
    n_checks++; if (bus.RES_VALID !== 1'b0) $display("FAIL reset_res_valid got=%b exp=0", bus.RES_VALID); else n_pass++;
    n_checks++; if (bus.RES_DATA !== 4'd0) $display("FAIL reset_res_data got=%h exp=0", bus.RES_DATA); else n_pass++;
    n_checks++; if (bus.RES_ID !== 2'd0) $display("FAIL reset_res_id got=%h exp=0", bus.RES_ID); else n_pass++;
    n_checks++; if (bus.BUSY !== 1'b0) $display("FAIL reset_busy got=%b exp=0", bus.BUSY); else n_pass++;
    n_checks++; if (bus.OP_COUNT !== 16'd0) $display("FAIL reset_op_count got=%h exp=0", bus.OP_COUNT); else n_pass++;
    @(negedge clk); #1;
    rst_n = 1'b1;
    m_ptr = 0; m_ops = 0;
  endtask

  task automatic test_single();
    logic [5:0] e;
    int c;
    bus.RES_READY = 1'b0;
    bus.REQ_A = 4'b0100; bus.REQ_B = 4'b0100; bus.REQ_VALID = 4'b0100;
    exp_q.push_back({2'd2, 4'd5});
    m_ptr = 3;
    #1;
    n_checks++; if (bus.REQ_READY !== 4'b0100) $display("FAIL single_grant got=%b exp=0100", bus.REQ_READY); else n_pass++;
    @(negedge clk); #1;
    bus.REQ_VALID = 4'b0000;
    n_checks++; if (bus.REQ_READY !== 4'b0000) $display("FAIL single_ready_calc got=%b exp=0000", bus.REQ_READY); else n_pass++;
    n_checks++; if (bus.RES_VALID !== 1'b0) $display("FAIL single_valid_calc got=%b exp=0", bus.RES_VALID); else n_pass++;
    @(negedge clk); #1;
    n_checks++; if (bus.RES_VALID !== 1'b1) $display("FAIL single_latency got=%b exp=1", bus.RES_VALID); else n_pass++;
    c = 0;
    while (!bus.RES_VALID && c < 10) begin @(negedge clk); #1; c++; end
    e = exp_q.pop_front();
    n_checks++; if ({bus.RES_ID, bus.RES_DATA} !== e) $display("FAIL single_result got=%h exp=%h", {bus.RES_ID, bus.RES_DATA}, e); else n_pass++;
    bus.RES_READY = 1'b1;
    @(negedge clk); #1;
    m_ops++;
    n_checks++; if (bus.OP_COUNT !== 16'(m_ops)) $display("FAIL single_op_count got=%0d exp=%0d", bus.OP_COUNT, m_ops); else n_pass++;
    n_checks++; if (bus.RES_VALID !== 1'b0) $display("FAIL single_valid_after got=%b exp=0", bus.RES_VALID); else n_pass++;
  endtask

  task automatic test_round_robin();
    logic [5:0] e;
    logic [3:0] er;
    int c, g, last;
    rst_n = 1'b0; #2; rst_n = 1'b1;
    m_ptr = 0; m_ops = 0; exp_q.delete();
    bus.REQ_A = 4'($urandom_range(0, 15));
    bus.REQ_B = 4'($urandom_range(0, 15));
    bus.REQ_VALID = 4'hF;
    bus.RES_READY = 1'b1;
    for (int k = 0; k < 5; k++) begin
      g = model_pick(4'hF, m_ptr);
      m_ptr = (g + 1) % 4;
      exp_q.push_back({2'(g), model_res(bus.REQ_A[g], bus.REQ_B[g])});
    end
    #1;
    last = 0;
    for (int k = 0; k < 5; k++) begin
      c = 0;
      while (bus.REQ_READY == 4'b0 && c < 10) begin @(negedge clk); #1; c++; end
      e = exp_q[0];
      er = 4'b0001 << e[5:4];
      n_checks++; if (bus.REQ_READY !== er) $display("FAIL rr_grant%0d got=%b exp=%b", k, bus.REQ_READY, er); else n_pass++;
      if (k > 0) begin
        n_checks++; if (cyc - last !== 3) $display("FAIL rr_spacing%0d got=%0d exp=3", k, cyc - last); else n_pass++;
      end
      last = cyc;
      @(negedge clk); #1;
      if (k == 4) bus.REQ_VALID = 4'b0;
      c = 0;
      while (!bus.RES_VALID && c < 10) begin @(negedge clk); #1; c++; end
      e = exp_q.pop_front();
      n_checks++; if ({bus.RES_ID, bus.RES_DATA} !== e) $display("FAIL rr_result%0d got=%h exp=%h", k, {bus.RES_ID, bus.RES_DATA}, e); else n_pass++;
    end
    @(negedge clk); #1;
    m_ops = 5;
    n_checks++; if (bus.OP_COUNT !== 16'd5) $display("FAIL rr_op_count got=%0d exp=5", bus.OP_COUNT); else n_pass++;
    n_checks++; if (bus.BUSY !== 1'b0) $display("FAIL rr_busy_end got=%b exp=0", bus.BUSY); else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [5:0] e;
    logic [3:0] er;
    int c, g;
    bus.RES_READY = 1'b0;
    bus.REQ_A = 4'($urandom_range(0, 15));
    bus.REQ_B = 4'($urandom_range(0, 15));
    bus.REQ_VALID = 4'b0010;
    g = model_pick(4'b0010, m_ptr); m_ptr = (g + 1) % 4;
    exp_q.push_back({2'(g), model_res(bus.REQ_A[g], bus.REQ_B[g])});
    #1;
    n_checks++; if (bus.REQ_READY !== 4'b0010) $display("FAIL bp_grant got=%b exp=0010", bus.REQ_READY); else n_pass++;
    @(negedge clk); #1;
    bus.REQ_VALID = 4'b1001;
    c = 0;
    while (!bus.RES_VALID && c < 10) begin @(negedge clk); #1; c++; end
    e = exp_q.pop_front();
    n_checks++; if ({bus.RES_ID, bus.RES_DATA} !== e) $display("FAIL bp_result got=%h exp=%h", {bus.RES_ID, bus.RES_DATA}, e); else n_pass++;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #1;
      bus.REQ_A = 4'($urandom_range(0, 15));
      n_checks++; if (bus.REQ_READY !== 4'b0) $display("FAIL bp_no_grant%0d got=%b exp=0000", k, bus.REQ_READY); else n_pass++;
      n_checks++; if (bus.RES_VALID !== 1'b1) $display("FAIL bp_valid%0d got=%b exp=1", k, bus.RES_VALID); else n_pass++;
      n_checks++; if ({bus.RES_ID, bus.RES_DATA} !== e) $display("FAIL bp_stable%0d got=%h exp=%h", k, {bus.RES_ID, bus.RES_DATA}, e); else n_pass++;
    end
    bus.RES_READY = 1'b1;
    g = model_pick(4'b1001, m_ptr); m_ptr = (g + 1) % 4;
    exp_q.push_back({2'(g), model_res(bus.REQ_A[g], bus.REQ_B[g])});
    er = 4'b0001 << g;
    @(negedge clk); #1;
    m_ops++;
    n_checks++; if (bus.OP_COUNT !== 16'(m_ops)) $display("FAIL bp_op_count got=%0d exp=%0d", bus.OP_COUNT, m_ops); else n_pass++;
    n_checks++; if (bus.REQ_READY !== er) $display("FAIL bp_pending_grant got=%b exp=%b", bus.REQ_READY, er); else n_pass++;
    @(negedge clk); #1;
    bus.REQ_VALID = 4'b0001;
    bus.REQ_A = ~bus.REQ_A;
    c = 0;
    while (!bus.RES_VALID && c < 10) begin @(negedge clk); #1; c++; end
    e = exp_q.pop_front();
    n_checks++; if ({bus.RES_ID, bus.RES_DATA} !== e) $display("FAIL bp_pending_result got=%h exp=%h", {bus.RES_ID, bus.RES_DATA}, e); else n_pass++;
    @(negedge clk); #1;
    m_ops++;
    g = model_pick(4'b0001, m_ptr); m_ptr = (g + 1) % 4;
    exp_q.push_back({2'(g), model_res(bus.REQ_A[g], bus.REQ_B[g])});
    er = 4'b0001 << g;
    n_checks++; if (bus.REQ_READY !== er) $display("FAIL bp_last_grant got=%b exp=%b", bus.REQ_READY, er); else n_pass++;
    @(negedge clk); #1;
    bus.REQ_VALID = 4'b0;
    c = 0;
    while (!bus.RES_VALID && c < 10) begin @(negedge clk); #1; c++; end
    e = exp_q.pop_front();
    n_checks++; if ({bus.RES_ID, bus.RES_DATA} !== e) $display("FAIL bp_last_result got=%h exp=%h", {bus.RES_ID, bus.RES_DATA}, e); else n_pass++;
    @(negedge clk); #1;
    m_ops++;
    n_checks++; if (bus.OP_COUNT !== 16'(m_ops)) $display("FAIL bp_op_count_end got=%0d exp=%0d", bus.OP_COUNT, m_ops); else n_pass++;
  endtask

  task automatic test_arith();
    logic [5:0] e;
    logic [3:0] cases_a;
    int c, idx;
    cases_a = 4'b0010;
    for (int k = 0; k < 2; k++) begin
      idx = $urandom_range(0, 3);
      bus.RES_READY = 1'b1;
      bus.REQ_A = 4'b0; bus.REQ_B = 4'b0;
      bus.REQ_A[idx] = cases_a[k];
      bus.REQ_VALID = 4'b0001 << idx;
      m_ptr = (idx + 1) % 4;
      exp_q.push_back({2'(idx), (k == 0) ? 4'd3 : 4'd4});
      if (k == 0) begin
        bus2.REQ_A = 4'b1100; bus2.REQ_B = 4'b1100; bus2.REQ_VALID = 2'b10; bus2.RES_READY = 1'b1;
        bus3.REQ_A = 4'b1100; bus3.REQ_B = 4'b1100; bus3.REQ_VALID = 2'b10; bus3.RES_READY = 1'b1;
      end
      @(negedge clk); #1;
      bus.REQ_VALID = 4'b0; bus2.REQ_VALID = 2'b0; bus3.REQ_VALID = 2'b0;
      c = 0;
      while (!bus.RES_VALID && c < 10) begin @(negedge clk); #1; c++; end
      e = exp_q.pop_front();
      n_checks++; if ({bus.RES_ID, bus.RES_DATA} !== e) $display("FAIL arith_w1_%0d got=%h exp=%h", k, {bus.RES_ID, bus.RES_DATA}, e); else n_pass++;
      if (k == 0) begin
        n_checks++; if (bus2.RES_DATA !== 4'd9) $display("FAIL arith_w2_rw4 got=%0d exp=9", bus2.RES_DATA); else n_pass++;
        n_checks++; if (bus2.RES_ID !== 1'b1) $display("FAIL arith_w2_id got=%0d exp=1", bus2.RES_ID); else n_pass++;
        n_checks++; if (bus3.RES_DATA !== 3'd1) $display("FAIL arith_w2_rw3 got=%0d exp=1", bus3.RES_DATA); else n_pass++;
      end
      @(negedge clk); #1;
      m_ops++;
    end
  endtask

  task automatic test_random();
    logic [5:0] e;
    logic [3:0] mask, er;
    int c, g, dly;
    for (int k = 0; k < 12; k++) begin
      bus.RES_READY = 1'b0;
      mask = 4'($urandom_range(1, 15));
      bus.REQ_A = 4'($urandom_range(0, 15));
      bus.REQ_B = 4'($urandom_range(0, 15));
      bus.REQ_VALID = mask;
      g = model_pick(mask, m_ptr); m_ptr = (g + 1) % 4;
      exp_q.push_back({2'(g), model_res(bus.REQ_A[g], bus.REQ_B[g])});
      er = 4'b0001 << g;
      #1;
      n_checks++; if (bus.REQ_READY !== er) $display("FAIL rand_grant%0d got=%b exp=%b", k, bus.REQ_READY, er); else n_pass++;
      @(negedge clk); #1;
      bus.REQ_VALID = 4'b0;
      bus.REQ_A = ~bus.REQ_A;
      bus.REQ_B = ~bus.REQ_B;
      c = 0;
      while (!bus.RES_VALID && c < 10) begin @(negedge clk); #1; c++; end
      e = exp_q.pop_front();
      n_checks++; if ({bus.RES_ID, bus.RES_DATA} !== e) $display("FAIL rand_result%0d got=%h exp=%h", k, {bus.RES_ID, bus.RES_DATA}, e); else n_pass++;
      dly = $urandom_range(0, 3);
      for (int d = 0; d < dly; d++) begin @(negedge clk); #1; end
      bus.RES_READY = 1'b1;
      @(negedge clk); #1;
      m_ops++;
      n_checks++; if (bus.OP_COUNT !== 16'(m_ops)) $display("FAIL rand_op_count%0d got=%0d exp=%0d", k, bus.OP_COUNT, m_ops); else n_pass++;
    end
    bus.RES_READY = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [5:0] e;
    int c;
    bus.RES_READY = 1'b0;
    bus.REQ_A = 4'b1000; bus.REQ_B = 4'b1000; bus.REQ_VALID = 4'b1000;
    @(negedge clk); #1;
    bus.REQ_VALID = 4'b0;
    n_checks++; if (bus.BUSY !== 1'b1) $display("FAIL rmid_busy_calc got=%b exp=1", bus.BUSY); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++; if (bus.BUSY !== 1'b0) $display("FAIL rmid_busy got=%b exp=0", bus.BUSY); else n_pass++;
    n_checks++; if (bus.RES_ID !== 2'd0) $display("FAIL rmid_res_id got=%0d exp=0", bus.RES_ID); else n_pass++;
    n_checks++; if (bus.RES_DATA !== 4'd0) $display("FAIL rmid_res_data got=%0d exp=0", bus.RES_DATA); else n_pass++;
    n_checks++; if (bus.OP_COUNT !== 16'd0) $display("FAIL rmid_op_count got=%0d exp=0", bus.OP_COUNT); else n_pass++;
    @(negedge clk); #1;
    n_checks++; if (bus.RES_VALID !== 1'b0) $display("FAIL rmid_res_valid got=%b exp=0", bus.RES_VALID); else n_pass++;
    rst_n = 1'b1;
    exp_q.delete(); m_ptr = 0; m_ops = 0;
    bus.REQ_A = 4'b0110; bus.REQ_B = 4'b0000; bus.REQ_VALID = 4'b0110;
    exp_q.push_back({2'd1, 4'd4});
    m_ptr = 2;
    #1;
    n_checks++; if (bus.REQ_READY !== 4'b0010) $display("FAIL rmid_first_grant got=%b exp=0010", bus.REQ_READY); else n_pass++;
    @(negedge clk); #1;
    bus.REQ_VALID = 4'b0;
    c = 0;
    while (!bus.RES_VALID && c < 10) begin @(negedge clk); #1; c++; end
    e = exp_q.pop_front();
    n_checks++; if ({bus.RES_ID, bus.RES_DATA} !== e) $display("FAIL rmid_result got=%h exp=%h", {bus.RES_ID, bus.RES_DATA}, e); else n_pass++;
    bus.RES_READY = 1'b1;
    @(negedge clk); #1;
    m_ops = 1;
    n_checks++; if (bus.OP_COUNT !== 16'd1) $display("FAIL rmid_op_count_after got=%0d exp=1", bus.OP_COUNT); else n_pass++;
  endtask

  task automatic test_wrap();
    logic [5:0] e;
    int c, g;
    bus.RES_READY = 1'b0;
    force dut.op_count_q = 16'hFFFF;
    @(negedge clk); #1;
    release dut.op_count_q;
    #1;
    n_checks++; if (bus.OP_COUNT !== 16'hFFFF) $display("FAIL wrap_preload got=%h exp=ffff", bus.OP_COUNT); else n_pass++;
    bus.REQ_A = 4'($urandom_range(0, 15));
    bus.REQ_B = 4'($urandom_range(0, 15));
    bus.REQ_VALID = 4'b1111;
    g = model_pick(4'b1111, m_ptr); m_ptr = (g + 1) % 4;
    exp_q.push_back({2'(g), model_res(bus.REQ_A[g], bus.REQ_B[g])});
    @(negedge clk); #1;
    bus.REQ_VALID = 4'b0;
    c = 0;
    while (!bus.RES_VALID && c < 10) begin @(negedge clk); #1; c++; end
    e = exp_q.pop_front();
    n_checks++; if ({bus.RES_ID, bus.RES_DATA} !== e) $display("FAIL wrap_result got=%h exp=%h", {bus.RES_ID, bus.RES_DATA}, e); else n_pass++;
    bus.RES_READY = 1'b1;
    @(negedge clk); #1;
    n_checks++; if (bus.OP_COUNT !== 16'h0000) $display("FAIL wrap_op_count got=%h exp=0000", bus.OP_COUNT); else n_pass++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    bus.REQ_VALID = '0; bus.REQ_A = '0; bus.REQ_B = '0; bus.RES_READY = 1'b0;
    bus2.REQ_VALID = '0; bus2.REQ_A = '0; bus2.REQ_B = '0; bus2.RES_READY = 1'b0;
    bus3.REQ_VALID = '0; bus3.REQ_A = '0; bus3.REQ_B = '0; bus3.RES_READY = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_arith();
    test_random();
    test_reset_mid();
    test_wrap();
    n_checks++; if (exp_q.size() !== 0) $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size()); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
